// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared types for the SPI transaction sequencer: FSM states, byte phases,
// the captured request header and the default filler byte.
package spi_xfer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSSU,
        ST_LOAD,
        ST_ISSUE,
        ST_WBSY,
        ST_WDON,
        ST_DLVR,
        ST_CSHD
    } state_e;

    typedef enum logic [1:0] {
        PH_CMD,
        PH_ADDR,
        PH_DUMMY,
        PH_DATA
    } phase_e;

    localparam logic [7:0] DUMMY_TX_DEFAULT = 8'h00;

    // Request fields held for the whole transaction (data length kept separately
    // because its width is a module parameter).
    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [1:0]  addr_len;
        logic [3:0]  dummy_len;
        logic        write;
    } req_hdr_t;

    // Address byte for a phase counter holding the number of bytes still to send
    // (3 -> addr[23:16], 2 -> addr[15:8], 1 -> addr[7:0]).
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] remaining);
        case (remaining)
            2'd3:    return addr[23:16];
            2'd2:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI transaction controller in front of a byte-level spi_master.
// Runs CMD, ADDR, DUMMY, DATA phases (empty phases skipped), one byte per master
// handshake, and owns chip-select for the whole transaction.
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_req_* / o_req_ready           transaction request (accepted only in IDLE)
//   i_wr_byte/i_wr_valid/o_wr_ready write-data stream (o_wr_ready pulses per byte taken)
//   o_rd_byte/o_rd_valid/i_rd_ready read-data stream (held until accepted)
//   o_busy, o_done                  status; o_done pulses as CS rises
//   o_spi_cs                        chip select, active low
//   o_mosi_*/i_mosi_ready/i_miso_*  byte interface to spi_master
module spi_xfer_sequencer
    import spi_xfer_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter logic [7:0]  DUMMY_TX = DUMMY_TX_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [7:0]       i_req_cmd,
    input  logic [23:0]      i_req_addr,
    input  logic [1:0]       i_req_addr_len,
    input  logic [3:0]       i_req_dummy_len,
    input  logic [LEN_W-1:0] i_req_len,
    input  logic             i_req_write,
    input  logic [7:0]       i_wr_byte,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    output logic [7:0]       o_rd_byte,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_spi_cs,
    output logic [7:0]       o_mosi_byte,
    output logic             o_mosi_dv,
    input  logic             i_mosi_ready,
    input  logic             i_miso_dv,
    input  logic [7:0]       i_miso_byte
);

    // Phase byte counter must also hold the 4-bit dummy length.
    localparam int unsigned CNT_W   = (LEN_W > 4) ? LEN_W : 4;
    localparam int unsigned TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    state_e           state_q, state_nx;
    phase_e           phase_q, phase_nx, adv_phase;
    logic [CNT_W-1:0] cnt_q, cnt_nx, adv_cnt;
    logic [TMR_W-1:0] tmr_q, tmr_nx;
    req_hdr_t         hdr_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       miso_q;
    logic [7:0]       sel_byte;
    logic             accept, take, deliver, advance, adv_last, done_nx;
    logic             data_wr, data_rd;

    assign data_wr = (phase_q == PH_DATA) &&  hdr_q.write;
    assign data_rd = (phase_q == PH_DATA) && !hdr_q.write;

    // Byte to present to the master for the current phase.
    always_comb begin
        sel_byte = DUMMY_TX;
        case (phase_q)
            PH_CMD:   sel_byte = hdr_q.cmd;
            PH_ADDR:  sel_byte = addr_byte(hdr_q.addr, cnt_q[1:0]);
            PH_DUMMY: sel_byte = DUMMY_TX;
            PH_DATA:  sel_byte = hdr_q.write ? i_wr_byte : DUMMY_TX;
            default:  sel_byte = DUMMY_TX;
        endcase
    end

    // Next-state, phase/counter advance and control strobes.
    always_comb begin
        state_nx  = state_q;
        phase_nx  = phase_q;
        cnt_nx    = cnt_q;
        tmr_nx    = tmr_q;
        accept    = 1'b0;
        take      = 1'b0;
        deliver   = 1'b0;
        advance   = 1'b0;
        done_nx   = 1'b0;
        adv_phase = phase_q;
        adv_cnt   = cnt_q - CNT_W'(1);
        adv_last  = 1'b0;

        // When the current phase is exhausted, jump to the next non-empty one.
        if (cnt_q <= CNT_W'(1)) begin
            if (phase_q == PH_CMD && hdr_q.addr_len != 2'd0) begin
                adv_phase = PH_ADDR;
                adv_cnt   = CNT_W'(hdr_q.addr_len);
            end else if ((phase_q == PH_CMD || phase_q == PH_ADDR) && hdr_q.dummy_len != 4'd0) begin
                adv_phase = PH_DUMMY;
                adv_cnt   = CNT_W'(hdr_q.dummy_len);
            end else if (phase_q != PH_DATA && len_q != '0) begin
                adv_phase = PH_DATA;
                adv_cnt   = CNT_W'(len_q);
            end else begin
                adv_last  = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    accept   = 1'b1;
                    state_nx = ST_CSSU;
                    tmr_nx   = TMR_W'(CS_SETUP - 1);
                    phase_nx = PH_CMD;
                    cnt_nx   = CNT_W'(1);
                end
            end
            ST_CSSU: begin
                if (tmr_q == '0) state_nx = ST_LOAD;
                else             tmr_nx   = tmr_q - TMR_W'(1);
            end
            ST_LOAD: begin
                if (i_mosi_ready && (!data_wr || i_wr_valid)) begin
                    take     = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i_mosi_ready) state_nx = ST_WBSY;
            end
            ST_WBSY: begin
                if (i_mosi_ready) state_nx = ST_WDON;
            end
            ST_WDON: begin
                if (data_rd) begin
                    deliver  = 1'b1;
                    state_nx = ST_DLVR;
                end else begin
                    advance  = 1'b1;
                end
            end
            ST_DLVR: begin
                if (i_rd_ready) advance = 1'b1;
            end
            ST_CSHD: begin
                if (tmr_q == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    tmr_nx   = tmr_q - TMR_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (advance) begin
            phase_nx = adv_phase;
            cnt_nx   = adv_cnt;
            if (adv_last) begin
                state_nx = ST_CSHD;
                tmr_nx   = TMR_W'(CS_HOLD - 1);
            end else begin
                state_nx = ST_LOAD;
            end
        end
    end

    // State, phase and timer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_CMD;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_nx;
            phase_q <= phase_nx;
            cnt_q   <= cnt_nx;
            tmr_q   <= tmr_nx;
        end
    end

    // Request capture, MISO capture and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hdr_q       <= '0;
            len_q       <= '0;
            miso_q      <= '0;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_spi_cs    <= 1'b1;
            o_done      <= 1'b0;
            o_mosi_dv   <= 1'b0;
            o_mosi_byte <= '0;
            o_wr_ready  <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_rd_byte   <= '0;
        end else begin
            // Ready only once IDLE has been held a full cycle, so it stays low through o_done.
            o_req_ready <= (state_q == ST_IDLE) && (state_nx == ST_IDLE);
            o_busy      <= (state_nx != ST_IDLE);
            o_spi_cs    <= (state_nx == ST_IDLE);
            o_done      <= done_nx;
            o_mosi_dv   <= take;
            o_wr_ready  <= take && data_wr;
            if (take) o_mosi_byte <= sel_byte;
            if (accept) begin
                hdr_q <= '{cmd:       i_req_cmd,
                           addr:      i_req_addr,
                           addr_len:  i_req_addr_len,
                           dummy_len: i_req_dummy_len,
                           write:     i_req_write};
                len_q <= i_req_len;
            end
            if ((state_q == ST_WBSY || state_q == ST_WDON) && i_miso_dv) miso_q <= i_miso_byte;
            // The master may flag MISO in the same cycle we leave WDON; bypass the capture.
            if (deliver) begin
                o_rd_valid <= 1'b1;
                o_rd_byte  <= i_miso_dv ? i_miso_byte : miso_q;
            end else if (state_q == ST_DLVR && i_rd_ready) begin
                o_rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a byte-level spi_master model and
// a queue-based transaction model (expected MOSI stream, expected read data).
module tb_spi_xfer_sequencer;
    import spi_xfer_sequencer_pkg::*;

    localparam int unsigned LEN_W    = 16;
    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_HOLD  = 2;
    localparam int unsigned BYTE_CYC = 2;
    localparam logic [7:0]  DTX      = 8'h00;

    logic             clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [7:0]       i_req_cmd;
    logic [23:0]      i_req_addr;
    logic [1:0]       i_req_addr_len;
    logic [3:0]       i_req_dummy_len;
    logic [LEN_W-1:0] i_req_len;
    logic             i_req_write;
    logic [7:0]       i_wr_byte;
    logic             i_wr_valid;
    logic             o_wr_ready;
    logic [7:0]       o_rd_byte;
    logic             o_rd_valid;
    logic             i_rd_ready;
    logic             o_busy;
    logic             o_done;
    logic             o_spi_cs;
    logic [7:0]       o_mosi_byte;
    logic             o_mosi_dv;
    logic             mosi_ready = 1'b1;
    logic             miso_dv = 1'b0;
    logic [7:0]       miso_byte = 8'h00;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(.LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .DUMMY_TX(DTX)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_cmd(i_req_cmd), .i_req_addr(i_req_addr), .i_req_addr_len(i_req_addr_len),
        .i_req_dummy_len(i_req_dummy_len), .i_req_len(i_req_len), .i_req_write(i_req_write),
        .i_wr_byte(i_wr_byte), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .o_rd_byte(o_rd_byte), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_busy(o_busy), .o_done(o_done), .o_spi_cs(o_spi_cs),
        .o_mosi_byte(o_mosi_byte), .o_mosi_dv(o_mosi_dv), .i_mosi_ready(mosi_ready),
        .i_miso_dv(miso_dv), .i_miso_byte(miso_byte)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Transaction model state
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rd[$];
    logic [7:0] slave_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] rd_log[$];
    logic [7:0] data_in[$];
    int done_cnt, wr_cnt, setup_cnt, hold_cnt, mosi_cnt, rd_seen;
    int stall_idx = -1, stall_len = 0, stall_ctr = 0, wr_delay = 0;
    bit first_dv;
    logic prev_dv = 1'b0, prev_cs = 1'b1;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] e_byte;

    // Byte-level spi_master: ready drops on dv, returns after BYTE_CYC+1 cycles with MISO.
    int m_cnt = 0;
    always @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            mosi_ready <= 1'b1;
            miso_dv    <= 1'b0;
            miso_byte  <= 8'h00;
            m_cnt      <= 0;
        end else begin
            miso_dv <= 1'b0;
            if (mosi_ready) begin
                if (o_mosi_dv) begin
                    mosi_ready <= 1'b0;
                    m_cnt      <= BYTE_CYC;
                end
            end else if (m_cnt == 0) begin
                mosi_ready <= 1'b1;
                miso_dv    <= 1'b1;
                if (slave_q.size() > 0) miso_byte <= slave_q.pop_front();
                else                    miso_byte <= 8'hEE;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Compare process: checks every cycle against the transaction model.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (!o_spi_cs && !first_dv && !o_mosi_dv) setup_cnt++;
            if (!o_spi_cs && first_dv && exp_mosi.size() == 0 && mosi_ready && !o_mosi_dv) hold_cnt++;
            if (o_mosi_dv) begin
                chk("mosi_pending", 32'(exp_mosi.size() > 0), 1);
                if (exp_mosi.size() > 0) begin
                    e_byte = exp_mosi.pop_front();
                    chk("mosi_byte", o_mosi_byte, e_byte);
                end
                chk("mosi_cs_low", o_spi_cs, 0);
                chk("mosi_dv_gap", prev_dv, 0);
                last_byte = o_mosi_byte;
                mosi_cnt++;
                first_dv = 1'b1;
            end else if (!mosi_ready) begin
                chk("mosi_hold", o_mosi_byte, last_byte);
            end
            if (o_rd_valid) begin
                chk("rd_no_issue", o_mosi_dv, 0);
                if (i_rd_ready) begin
                    chk("rd_pending", 32'(exp_rd.size() > 0), 1);
                    if (exp_rd.size() > 0) begin
                        e_byte = exp_rd.pop_front();
                        chk("rd_byte", o_rd_byte, e_byte);
                    end
                    rd_log.push_back(o_rd_byte);
                    rd_seen++;
                end
            end
            if (o_wr_ready) wr_cnt++;
            if (o_done) begin
                done_cnt++;
                chk("done_cs_high", o_spi_cs, 1);
                chk("done_prev_cs", prev_cs, 0);
                chk("done_req_ready", o_req_ready, 0);
            end
            prev_dv = o_mosi_dv;
            prev_cs = o_spi_cs;
        end
    end

    // Read-consumer driver with optional stall on one byte.
    initial begin
        i_rd_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (o_rd_valid === 1'b1 && rd_seen == stall_idx && stall_ctr < stall_len) begin
                i_rd_ready = 1'b0;
                stall_ctr++;
            end else begin
                i_rd_ready = 1'b1;
            end
        end
    end

    // Write-producer driver: holds each byte until o_wr_ready is seen.
    initial begin
        i_wr_valid = 1'b0;
        i_wr_byte  = 8'h00;
        forever begin
            @(posedge clk); #2;
            if (o_wr_ready === 1'b1 && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_delay > 0) wr_delay--;
            if (wr_q.size() > 0 && wr_delay == 0) begin
                i_wr_valid = 1'b1;
                i_wr_byte  = wr_q[0];
            end else begin
                i_wr_valid = 1'b0;
            end
        end
    end

    // Expected MOSI stream: cmd, low addr_len address bytes MSB first, dummies, data.
    task automatic build(input logic [7:0] cmd, input logic [23:0] addr, input int alen,
                         input int dlen, input int len, input bit wr, input int wdelay,
                         input int sidx, input int slen);
        logic [23:0] sh;
        exp_mosi.delete(); exp_rd.delete(); slave_q.delete(); wr_q.delete(); rd_log.delete();
        done_cnt = 0; wr_cnt = 0; setup_cnt = 0; hold_cnt = 0; mosi_cnt = 0; rd_seen = 0;
        first_dv = 1'b0; stall_idx = sidx; stall_len = slen; stall_ctr = 0;
        exp_mosi.push_back(cmd);
        for (int i = alen; i > 0; i--) begin
            sh = addr >> (8 * (i - 1));
            exp_mosi.push_back(sh[7:0]);
        end
        for (int i = 0; i < dlen; i++) exp_mosi.push_back(DTX);
        for (int i = 0; i < 1 + alen + dlen; i++) slave_q.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < len; i++) begin
            if (wr) begin
                exp_mosi.push_back(data_in[i]);
                slave_q.push_back(8'hD0 + 8'(i));
            end else begin
                exp_mosi.push_back(DTX);
                slave_q.push_back(data_in[i]);
                exp_rd.push_back(data_in[i]);
            end
        end
        i_req_cmd = cmd; i_req_addr = addr; i_req_addr_len = 2'(alen);
        i_req_dummy_len = 4'(dlen); i_req_len = LEN_W'(len); i_req_write = wr;
        wr_delay = wdelay;
        if (wr) for (int i = 0; i < len; i++) wr_q.push_back(data_in[i]);
    endtask

    // Called at posedge+2; presents the request for one accepting edge.
    task automatic issue();
        for (int n = 0; n < 200 && o_req_ready !== 1'b1; n++) begin
            @(posedge clk); #2;
        end
        chk("req_ready_before", o_req_ready, 1);
        i_req_valid = 1'b1;
        @(posedge clk); #2;
        i_req_valid = 1'b0;
        chk("cs_low_after_accept", o_spi_cs, 0);
        chk("busy_after_accept", o_busy, 1);
    endtask

    task automatic finish_txn(input int limit, input int exp_wr);
        for (int n = 0; n < limit && done_cnt == 0; n++) begin
            @(posedge clk); #2;
        end
        chk("done_seen", 32'(done_cnt > 0), 1);
        repeat (4) begin
            @(posedge clk); #2;
        end
        chk("done_once", done_cnt, 1);
        chk("mosi_left", exp_mosi.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_ready_cnt", wr_cnt, exp_wr);
        chk("cs_idle", o_spi_cs, 1);
        chk("req_ready_idle", o_req_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mc;
        i_req_valid = 1'b0; i_req_cmd = '0; i_req_addr = '0; i_req_addr_len = '0;
        i_req_dummy_len = '0; i_req_len = '0; i_req_write = 1'b0;
        #1 i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cs", o_spi_cs, 1);
        chk("rst_req_ready", o_req_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_mosi_dv", o_mosi_dv, 0);
        chk("rst_mosi_byte", o_mosi_byte, 0);
        chk("rst_wr_ready", o_wr_ready, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_rd_byte", o_rd_byte, 0);
        @(negedge clk); i_rst = 1'b0;
        @(posedge clk); #2;
        chk("req_ready_first_clk", o_req_ready, 1);

        // Read: 03 123456, 4 data bytes
        data_in = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        build(8'h03, 24'h123456, 3, 0, 4, 1'b0, 0, -1, 0);
        chk("pin_read_len", exp_mosi.size(), 8);
        chk("pin_read_b1", exp_mosi[1], 8'h12);
        chk("pin_read_b3", exp_mosi[3], 8'h56);
        chk("pin_read_b7", exp_mosi[7], 8'h00);
        issue();
        finish_txn(1000, 0);
        chk("read_mosi_cnt", mosi_cnt, 8);
        chk("read_rd_cnt", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            chk("read_rd0", rd_log[0], 8'hA1);
            chk("read_rd3", rd_log[3], 8'hA4);
        end

        // Write with delayed data stream, plus a request poked while busy
        data_in = '{8'h55, 8'hAA};
        build(8'h02, 24'h00007F, 1, 0, 2, 1'b1, 20, -1, 0);
        chk("pin_write_b1", exp_mosi[1], 8'h7F);
        chk("pin_write_b2", exp_mosi[2], 8'h55);
        issue();
        repeat (16) begin
            @(posedge clk); #2;
        end
        chk("wr_stall_pending", exp_mosi.size(), 2);
        chk("wr_stall_cs", o_spi_cs, 0);
        chk("busy_req_ready", o_req_ready, 0);
        i_req_cmd = 8'h9F; i_req_valid = 1'b1;
        @(posedge clk); #2;
        i_req_valid = 1'b0;
        finish_txn(1000, 2);
        chk("write_mosi_cnt", mosi_cnt, 4);
        mc = mosi_cnt;
        repeat (30) begin
            @(posedge clk); #2;
        end
        chk("busy_req_ignored_cs", o_spi_cs, 1);
        chk("busy_req_ignored_bytes", mosi_cnt, mc);

        // Minimal one-byte transaction: CS setup/hold timing
        data_in.delete();
        build(8'h06, 24'h0, 0, 0, 0, 1'b0, 0, -1, 0);
        issue();
        finish_txn(500, 0);
        chk("min_mosi_cnt", mosi_cnt, 1);
        chk("min_cs_setup", 32'(setup_cnt >= CS_SETUP && setup_cnt <= CS_SETUP + 1), 1);
        chk("min_cs_hold", 32'(hold_cnt >= CS_HOLD && hold_cnt <= CS_HOLD + 2), 1);

        // Read backpressure: consumer stalls 50 cycles on the second byte
        data_in = '{8'hB1, 8'hB2, 8'hB3};
        build(8'h0B, 24'h000010, 3, 1, 3, 1'b0, 0, 1, 50);
        issue();
        finish_txn(2000, 0);
        chk("bp_stall_len", stall_ctr, 50);
        chk("bp_mosi_cnt", mosi_cnt, 8);
        chk("bp_rd_cnt", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            chk("bp_rd0", rd_log[0], 8'hB1);
            chk("bp_rd1", rd_log[1], 8'hB2);
            chk("bp_rd2", rd_log[2], 8'hB3);
        end

        // Reset during the second address byte
        data_in = '{8'h11, 8'h22};
        build(8'h0B, 24'hABCDEF, 3, 0, 2, 1'b0, 0, -1, 0);
        issue();
        for (int n = 0; n < 300 && exp_mosi.size() > 3; n++) begin
            @(posedge clk); #2;
        end
        chk("rst_mid_reached", exp_mosi.size(), 3);
        #1 i_rst = 1'b1;
        #1;
        chk("abort_cs", o_spi_cs, 1);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_dv", o_mosi_dv, 0);
        chk("abort_req_ready", o_req_ready, 0);
        chk("abort_rd_valid", o_rd_valid, 0);
        chk("abort_mosi_byte", o_mosi_byte, 0);
        exp_mosi.delete(); exp_rd.delete(); slave_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); i_rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #2;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_cs_idle", o_spi_cs, 1);

        // Clean request after the abort
        data_in.delete();
        build(8'h05, 24'h0, 0, 0, 0, 1'b0, 0, -1, 0);
        issue();
        finish_txn(500, 0);
        chk("post_abort_mosi_cnt", mosi_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
